// File: rtl/regfile_n.sv
// Parameterised register file: two combinational read ports, one write port, FSM-driven bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_n #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cload,
  input  logic [ADDR_W-1:0] csel,
  input  logic [DATA_W-1:0] cin,
  input  logic [ADDR_W-1:0] asel,
  input  logic [ADDR_W-1:0] bsel,
  input  logic              clr,
  output logic [DATA_W-1:0] aout,
  output logic [DATA_W-1:0] bout,
  output logic              busy,
  output logic              done,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_done;
  logic              r_wr_drop;
  logic              w_busy;
  logic              w_last;
  logic              w_wr_en;
  logic              w_a_zero;
  logic              w_b_zero;

  assign w_busy   = (r_state == CLEAR);
  assign w_a_zero = (ZERO_REG != 0) && (asel == '0);
  assign w_b_zero = (ZERO_REG != 0) && (bsel == '0);
  assign w_wr_en  = cload && !w_busy &&
                    !((ZERO_REG != 0) && (csel == '0));

  always_comb begin
    w_state_nx = r_state;
    w_last     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (clr) w_state_nx = CLEAR;
      end
      CLEAR: begin
        if (r_ptr == LAST) begin
          w_state_nx = IDLE;
          w_last     = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // clr during a sweep is ignored; ptr simply wraps back to 0 at LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_done    <= 1'b0;
      r_wr_drop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_done    <= w_last;
      r_wr_drop <= cload && w_busy;
      if (w_busy) begin
        r_mem[r_ptr] <= '0;
        r_ptr        <= r_ptr + 1'b1;
      end else if (clr) begin
        r_ptr <= '0;
      end
      if (w_wr_en) r_mem[csel] <= cin;
    end
  end

  always_comb begin
    aout = r_mem[asel];
`ifdef REGFILE_BYPASS_EN
    if (cload && !w_busy && (csel == asel)) aout = cin;
`endif
    if (w_a_zero) aout = '0;
  end

  always_comb begin
    bout = r_mem[bsel];
`ifdef REGFILE_BYPASS_EN
    if (cload && !w_busy && (csel == bsel)) bout = cin;
`endif
    if (w_b_zero) bout = '0;
  end

  assign busy    = w_busy;
  assign done    = r_done;
  assign wr_drop = r_wr_drop;

endmodule

// File: doc/regfile_n.md
REGFILE_N -- requirements
Module: regfile_n

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cload  input  1  write enable for write port C.
REQ-007 SHALL have port csel  input  ADDR_W  write address.
REQ-008 SHALL have port cin  input  DATA_W  write data.
REQ-009 SHALL have port asel  input  ADDR_W  read address, port A.
REQ-010 SHALL have port bsel  input  ADDR_W  read address, port B.
REQ-011 SHALL have port clr  input  1  bulk-clear request, sampled each cycle.
REQ-012 SHALL have port aout  output  DATA_W  read data, port A.
REQ-013 SHALL have port bout  output  DATA_W  read data, port B.
REQ-014 SHALL have port busy  output  1  high while a bulk clear is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse on the cycle after the last register is cleared.
REQ-016 SHALL have port wr_drop  output  1  one-cycle pulse when a write is discarded.

Function
REQ-017 Reads SHALL be combinational: aout = reg[asel], bout = reg[bsel], with no cycle of latency.
REQ-018 A write SHALL occur at the clock edge when cload=1 and busy=0: reg[csel] <= cin, visible on aout/bout from the next cycle.
REQ-019 With ZERO_REG=1, a read of address 0 SHALL return 0, a write to address 0 SHALL be discarded without a wr_drop pulse, and the clear sweep SHALL still visit address 0.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR; busy = (state == CLEAR).
REQ-021 In IDLE, clr=1 SHALL set ptr <= 0 and the state to CLEAR at the next edge.
REQ-022 In CLEAR, each edge SHALL set reg[ptr] <= 0 and ptr <= ptr+1, so the sweep takes exactly DEPTH cycles.
REQ-023 When ptr == DEPTH-1 in CLEAR, the next edge SHALL return the state to IDLE and set done=1 for one cycle.
REQ-024 clr asserted while busy=1 SHALL be ignored: no restart and no extension of the sweep.
REQ-025 If cload=1 and clr=1 in the same IDLE cycle, the write SHALL commit at that edge and CLEAR SHALL start at the same edge; the written value is later zeroed by the sweep.
REQ-026 cload=1 while busy=1 SHALL discard the write and set wr_drop=1 on the following cycle.
REQ-027 During CLEAR, reads SHALL return live contents: swept registers return 0 and unswept registers return their old values.
REQ-028 ptr SHALL be ADDR_W bits wide and SHALL wrap from DEPTH-1 to 0 with no extra state.

Reset
REQ-029 rst=1 at an edge SHALL zero every register, set the state to IDLE, set ptr=0, and clear busy, done and wr_drop.
REQ-030 rst SHALL take priority over cload and clr in the same cycle.
REQ-031 rst during CLEAR SHALL abort the sweep: the state becomes IDLE with no done pulse.
REQ-032 After reset, aout=0, bout=0, busy=0, done=0 and wr_drop=0 SHALL hold until the first write or clear.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN, when defined, SHALL forward write data: if cload=1, busy=0 and csel==asel, then aout=cin in the same cycle; the same rule applies to bsel/bout.
REQ-034 With REGFILE_BYPASS_EN defined and ZERO_REG=1, address 0 SHALL never be forwarded and SHALL read 0.
REQ-035 Without REGFILE_BYPASS_EN, aout and bout SHALL show the stored value only and SHALL update the cycle after the write.

Verification
REQ-036 Default parameters: reset, then write 0xA5 to reg 3 -> asel=3 reads 0xA5 from the next cycle, and bsel=4 reads 0x00.
REQ-037 Default parameters: fill regs 0..7 with 0x11..0x88, pulse clr -> busy=1 for 8 cycles, reg k reads 0 from cycle k+1, done pulses once, then busy=0.
REQ-038 Write during busy, cload=1 with csel=5 and cin=0xFF at sweep cycle 2 -> reg 5 reads 0 after the sweep, and wr_drop pulses once.
REQ-039 rst at sweep cycle 3 -> busy=0 the next cycle, all regs read 0, and no done pulse.
REQ-040 With REGFILE_BYPASS_EN defined: cload=1, csel=asel=2, cin=0x3C -> aout=0x3C in the same cycle; without the macro, aout shows the old value that cycle and 0x3C the next.
REQ-041 With ZERO_REG=1 and DATA_W=16: write 0xBEEF to reg 0 -> reg 0 reads 0x0000, with no wr_drop pulse.
